reg_strobe_fifo: RTL and testbench
==================================

# reg_strobe_fifo

Command buffer downstream of a register bank that produces a one-cycle write strobe per register write. Each strobe captures the register's field value into a small FIFO, so every software write becomes exactly one command for a slower consumer on a valid/ready interface. Writes arriving while the FIFO is full are dropped and flagged. The consumer never needs to keep pace with bus write bursts.

## Interface
Parameters:
- DATA_W, 32, width of captured register value / command word
- DEPTH, 4, number of entries; power of two, ≥2

Ports:
- Timing: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset
- wr_i  in  1  write strobe from register bank; one-cycle pulse per write
- data_i  in  DATA_W  register field value; valid in the cycle wr_i is high
- cmd_valid_o  out  1  head entry available
- cmd_ready_i  in  1  consumer accepts head entry
- cmd_data_o  out  DATA_W  head entry contents
- level_o  out  $clog2(DEPTH)+1  number of stored entries
- full_o  out  1  level_o == DEPTH
- empty_o  out  1  level_o == 0
- overflow_o  out  1  sticky; a strobe was dropped
- overflow_clr_i  in  1  clears overflow_o
- ovf_cnt_o  out  8  dropped-strobe count (see Configuration)

## Operation
- Push: wr_i=1 and (not full, or pop in the same cycle). Writes data_i at the write pointer. Advances the write pointer modulo DEPTH.
- Pop: cmd_valid_o=1 and cmd_ready_i=1. Advances the read pointer modulo DEPTH.
- cmd_valid_o = !empty_o. cmd_data_o = mem[rd_ptr], driven straight from storage. cmd_data_o is don't-care when not valid and must not depend on cmd_ready_i.
- Push and pop in the same cycle: level unchanged. This holds when full, so a strobe arriving on a full FIFO is accepted if the head is popped that cycle.
- Drop: wr_i=1, full, no pop. Entry is discarded, storage is unchanged, overflow_o is set.
- overflow_clr_i and a drop in the same cycle: set wins, overflow_o stays 1.
- No bypass. A strobe into an empty FIFO is not visible on cmd_* in the same cycle.
- Pointers carry one extra wrap bit; level_o = wr_ptr - rd_ptr (unsigned, $clog2(DEPTH)+1 bits).

## Timing
Reset values:
- cmd_valid_o=0, level_o=0, empty_o=1, full_o=0, overflow_o=0, ovf_cnt_o=0.
- Pointers reset to 0. cmd_data_o is undefined.

Latency:
- wr_i at edge N into an empty FIFO gives cmd_valid_o=1 and cmd_data_o=data_i in cycle N+1.
- Pop at edge N updates cmd_data_o to the next entry in cycle N+1.

Throughput and flags:
- Throughput is one push and one pop per cycle.
- level_o, full_o and empty_o are registered-state derived and update the cycle after the event.

Reset mid-operation:
- rst_i high at an edge flushes all entries and clears overflow state.
- wr_i and cmd_ready_i are ignored in any cycle rst_i is high.

## Configuration
- Macro REG_STROBE_FIFO_OVF_CNT_EN.
- Defined: ovf_cnt_o increments once per dropped strobe and saturates at 255. overflow_clr_i clears it to 0. A drop in the same cycle as the clear leaves it at 1.
- Undefined: ovf_cnt_o is tied to 0 and no counter flops are generated. The port list is unchanged.

## Structure
- Package reg_strobe_fifo_pkg holds:
  - default constants: DATA_W_DEF=32, DEPTH_DEF=4, OVF_CNT_W=8
  - function clog2 used for pointer width
- Sub-module reg_strobe_fifo_mem: DEPTH×DATA_W register array, one write port (we, waddr, wdata), one asynchronous read port. No reset on storage.
- Top level holds pointers, flags, overflow and counter logic.

## Test plan
- Reset, then wr_i pulse with data_i=0xA5A5_0001, cmd_ready_i=0 → cmd_valid_o=1 next cycle, cmd_data_o=0xA5A5_0001, level_o=1.
- Four strobes (0x1..0x4) back-to-back, ready=0 → full_o=1, level_o=4. A fifth strobe 0x5 → dropped, overflow_o=1, ovf_cnt_o=1 (macro on). Drain yields exactly 0x1,0x2,0x3,0x4.
- Full FIFO with strobe 0x9 and pop in the same cycle → 0x9 accepted, level_o stays 4. Later drain ends with 0x9.
- 300 dropped strobes with macro on → ovf_cnt_o=255. overflow_clr_i together with a drop → overflow_o=1, ovf_cnt_o=1.
- Random wr_i/cmd_ready_i for 10k cycles with DEPTH=8, including wrap-around → scoreboard order matches, no loss except counted drops.
- rst_i asserted with level_o=3 and wr_i high → next cycle empty_o=1, cmd_valid_o=0, overflow_o=0, strobe not stored.

Source files
------------

// File: rtl/reg_strobe_fifo_pkg.sv
// -----------------------------------------------------------------------------
// reg_strobe_fifo_pkg
// Shared constants and helpers for the register-strobe command FIFO.
//   DATA_W_DEF : default command word width
//   DEPTH_DEF  : default number of FIFO entries
//   OVF_CNT_W  : width of the dropped-strobe counter port
//   clog2()    : ceiling log2, used to size pointers and the level output
// -----------------------------------------------------------------------------
package reg_strobe_fifo_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;
    localparam int OVF_CNT_W  = 8;

    // Ceiling log2 for v >= 1; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_strobe_fifo_mem.sv
// -----------------------------------------------------------------------------
// reg_strobe_fifo_mem
// DEPTH x DATA_W register array for the command FIFO. No reset on storage.
// Ports:
//   clk_i   : clock, write on rising edge
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address (asynchronous read)
//   rdata_o : read data, combinational from the array
// -----------------------------------------------------------------------------
module reg_strobe_fifo_mem
    import reg_strobe_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [clog2(DEPTH)-1:0]   waddr_i,
    input  logic [DATA_W-1:0]         wdata_i,
    input  logic [clog2(DEPTH)-1:0]   raddr_i,
    output logic [DATA_W-1:0]         rdata_o
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/reg_strobe_fifo.sv
// -----------------------------------------------------------------------------
// reg_strobe_fifo
// Captures each one-cycle register write strobe into a small FIFO and presents
// the entries as commands on a valid/ready interface. Strobes arriving while
// the FIFO is full (and not popped that cycle) are dropped and flagged.
//
// Handshake: a command transfers on a rising edge where cmd_valid_o and
// cmd_ready_i are both high; cmd_valid_o and cmd_data_o depend only on stored
// state, never on cmd_ready_i.
//
// Optional feature: define REG_STROBE_FIFO_OVF_CNT_EN to build the saturating
// dropped-strobe counter; otherwise ovf_cnt_o is tied to zero.
//
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   wr_i, data_i     : write strobe and the register value to capture
//   cmd_valid_o      : head entry available
//   cmd_ready_i      : consumer accepts head entry
//   cmd_data_o       : head entry contents
//   level_o          : stored entry count
//   full_o, empty_o  : level_o == DEPTH / level_o == 0
//   overflow_o       : sticky drop flag
//   overflow_clr_i   : clears overflow_o (and the counter)
//   ovf_cnt_o        : dropped-strobe count
// -----------------------------------------------------------------------------
module reg_strobe_fifo
    import reg_strobe_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wr_i,
    input  logic [DATA_W-1:0]       data_i,
    output logic                    cmd_valid_o,
    input  logic                    cmd_ready_i,
    output logic [DATA_W-1:0]       cmd_data_o,
    output logic [clog2(DEPTH):0]   level_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    overflow_o,
    input  logic                    overflow_clr_i,
    output logic [OVF_CNT_W-1:0]    ovf_cnt_o
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic              r_overflow;

    logic [PW-1:0]     w_level;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_rdata;

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_level == DEPTH_P);
    assign w_empty = (w_level == '0);

    assign w_pop  = !w_empty && cmd_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push = wr_i && (!w_full || w_pop);
    assign w_drop = wr_i && w_full && !w_pop;

    // Storage is left untouched while reset is applied.
    assign w_mem_we = w_push && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Setting wins over clearing when both happen in one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr_i) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef REG_STROBE_FIFO_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] r_ovf_cnt;

    // Clear with a simultaneous drop restarts the count at one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ovf_cnt <= '0;
        end else if (overflow_clr_i) begin
            r_ovf_cnt <= w_drop ? OVF_CNT_W'(1) : '0;
        end else if (w_drop && (r_ovf_cnt != '1)) begin
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
    end

    assign ovf_cnt_o = r_ovf_cnt;
`else
    assign ovf_cnt_o = '0;
`endif

    reg_strobe_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (w_mem_we),
        .waddr_i (r_wr_ptr[AW-1:0]),
        .wdata_i (data_i),
        .raddr_i (r_rd_ptr[AW-1:0]),
        .rdata_o (w_rdata)
    );

    assign cmd_valid_o = !w_empty;
    assign cmd_data_o  = w_rdata;
    assign level_o     = w_level;
    assign full_o      = w_full;
    assign empty_o     = w_empty;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_reg_strobe_fifo.sv
// -----------------------------------------------------------------------------
// tb_reg_strobe_fifo
// Drives a DEPTH=4 and a DEPTH=8 instance with the same stimulus. A table of
// single-cycle vectors checks the DEPTH=4 flags against fixed values; a queue
// model per instance checks command order, level and overflow state each cycle.
// -----------------------------------------------------------------------------
module tb_reg_strobe_fifo;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic [31:0] data;
    logic        rdy;
    logic        clr;

    always #5 clk = ~clk;

    logic        valid4, full4, empty4, ovf4_o;
    logic [31:0] cdata4;
    logic [2:0]  level4;
    logic [7:0]  cnt4_o;

    logic        valid8, full8, empty8, ovf8_o;
    logic [31:0] cdata8;
    logic [3:0]  level8;
    logic [7:0]  cnt8_o;

    reg_strobe_fifo #(.DATA_W(32), .DEPTH(4)) dut4 (
        .clk_i (clk), .rst_i (rst), .wr_i (wr), .data_i (data),
        .cmd_valid_o (valid4), .cmd_ready_i (rdy), .cmd_data_o (cdata4),
        .level_o (level4), .full_o (full4), .empty_o (empty4),
        .overflow_o (ovf4_o), .overflow_clr_i (clr), .ovf_cnt_o (cnt4_o)
    );

    reg_strobe_fifo #(.DATA_W(32), .DEPTH(8)) dut8 (
        .clk_i (clk), .rst_i (rst), .wr_i (wr), .data_i (data),
        .cmd_valid_o (valid8), .cmd_ready_i (rdy), .cmd_data_o (cdata8),
        .level_o (level8), .full_o (full8), .empty_o (empty8),
        .overflow_o (ovf8_o), .overflow_clr_i (clr), .ovf_cnt_o (cnt8_o)
    );

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q4[$];
    logic [31:0] exp_q8[$];
    int m_ovf4, m_cnt4, m_ovf8, m_cnt8;
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int exp_cnt(input int c);
`ifdef REG_STROBE_FIFO_OVF_CNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    // ---------------- driver: one clock cycle ----------------
    // Called #1 after a rising edge; returns #1 after the next rising edge.
    task automatic step(input logic i_wr, input logic [31:0] i_d, input logic i_rdy,
                        input logic i_clr, input logic i_rst);
        int  n;
        logic pop, drop;
        wr = i_wr; data = i_d; rdy = i_rdy; clr = i_clr; rst = i_rst;
        #1;
        if (i_rst) begin
            exp_q4.delete(); m_ovf4 = 0; m_cnt4 = 0;
            exp_q8.delete(); m_ovf8 = 0; m_cnt8 = 0;
        end else begin
            n = exp_q4.size();
            pop = (n > 0) && i_rdy;
            if (pop) begin
                chk("d4_head", cdata4, exp_q4[0]);
                void'(exp_q4.pop_front());
            end
            drop = i_wr && (n == 4) && !pop;
            if (i_wr && !drop) exp_q4.push_back(i_d);
            if (drop) begin
                m_ovf4 = 1;
                m_cnt4 = i_clr ? 1 : ((m_cnt4 == 255) ? 255 : m_cnt4 + 1);
            end else if (i_clr) begin
                m_ovf4 = 0; m_cnt4 = 0;
            end

            n = exp_q8.size();
            pop = (n > 0) && i_rdy;
            if (pop) begin
                chk("d8_head", cdata8, exp_q8[0]);
                void'(exp_q8.pop_front());
            end
            drop = i_wr && (n == 8) && !pop;
            if (i_wr && !drop) exp_q8.push_back(i_d);
            if (drop) begin
                m_ovf8 = 1;
                m_cnt8 = i_clr ? 1 : ((m_cnt8 == 255) ? 255 : m_cnt8 + 1);
            end else if (i_clr) begin
                m_ovf8 = 0; m_cnt8 = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("d4_level", 32'(level4), 32'(exp_q4.size()));
        chk("d4_valid", 32'(valid4), 32'(exp_q4.size() > 0));
        chk("d4_ovf",   32'(ovf4_o), 32'(m_ovf4));
        chk("d4_cnt",   32'(cnt4_o), 32'(exp_cnt(m_cnt4)));
        chk("d8_level", 32'(level8), 32'(exp_q8.size()));
        chk("d8_full",  32'(full8),  32'(exp_q8.size() == 8));
        chk("d8_empty", 32'(empty8), 32'(exp_q8.size() == 0));
        chk("d8_ovf",   32'(ovf8_o), 32'(m_ovf8));
        chk("d8_cnt",   32'(cnt8_o), 32'(exp_cnt(m_cnt8)));
    endtask

    // ---------------- directed vector table (DEPTH=4 expectations) ----------------
    typedef struct packed {
        logic        wr;
        logic [31:0] d;
        logic        rdy;
        logic        clr;
        logic        e_valid;
        logic [2:0]  e_level;
        logic        e_full;
        logic        e_empty;
        logic        e_ovf;
    } vec_t;

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 32'h1,         1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 32'h2,         1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 32'h3,         1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 32'h4,         1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 32'h5,         1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 32'h9,         1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};

        m_ovf4 = 0; m_cnt4 = 0; m_ovf8 = 0; m_cnt8 = 0;
        rst = 1'b1; wr = 1'b0; data = '0; rdy = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(valid4), 32'd0);
        chk("rst_level", 32'(level4), 32'd0);
        chk("rst_empty", 32'(empty4), 32'd1);
        chk("rst_full",  32'(full4),  32'd0);
        chk("rst_ovf",   32'(ovf4_o), 32'd0);
        chk("rst_cnt",   32'(cnt4_o), 32'd0);
        chk("rst_empty8", 32'(empty8), 32'd1);
        @(posedge clk);
        #1;

        // Table: first strobe latency, fill, drop, push+pop on full, clear, drain.
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].wr, tbl[i].d, tbl[i].rdy, tbl[i].clr, 1'b0);
            chk($sformatf("tbl%0d_valid", i), 32'(valid4), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_level", i), 32'(level4), 32'(tbl[i].e_level));
            chk($sformatf("tbl%0d_full", i),  32'(full4),  32'(tbl[i].e_full));
            chk($sformatf("tbl%0d_empty", i), 32'(empty4), 32'(tbl[i].e_empty));
            chk($sformatf("tbl%0d_ovf", i),   32'(ovf4_o), 32'(tbl[i].e_ovf));
            if (i == 0) chk("first_data", cdata4, 32'hA5A5_0001);
        end

        // Saturation: fill, then 300 dropped strobes.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 32'hDEAD_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        chk("sat_cnt", 32'(cnt4_o), 32'(exp_cnt(255)));
        chk("sat_ovf", 32'(ovf4_o), 32'd1);

        // Clear together with a drop: set wins, counter restarts at one.
        step(1'b1, 32'hBEEF, 1'b0, 1'b1, 1'b0);
        chk("clrdrop_ovf", 32'(ovf4_o), 32'd1);
        chk("clrdrop_cnt", 32'(cnt4_o), 32'(exp_cnt(1)));
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("clr_ovf", 32'(ovf4_o), 32'd0);
        chk("clr_cnt", 32'(cnt4_o), 32'd0);

        // Reset mid-operation with level 3, overflow set, and a strobe pending.
        step(1'b1, 32'hC0DE, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_level", 32'(level4), 32'd3);
        chk("pre_rst_ovf",   32'(ovf4_o), 32'd1);
        step(1'b1, 32'h7777_7777, 1'b1, 1'b0, 1'b1);
        chk("mid_rst_empty", 32'(empty4), 32'd1);
        chk("mid_rst_valid", 32'(valid4), 32'd0);
        chk("mid_rst_ovf",   32'(ovf4_o), 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_level", 32'(level4), 32'd0);

        // Random traffic with wrap-around on both depths.
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 2, 1'b0);
        end
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("final_empty4", 32'(empty4), 32'd1);
        chk("final_empty8", 32'(empty8), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
